// File: rtl/dlx_control.sv
// ----------------------------------------------------------------------------
// dlx_control -- multi-cycle DLX controller
//
// Sequences each instruction through IDLE -> FETCH -> DECODE -> EXEC
// [-> MEM] [-> WB] -> FETCH. The state is registered. Every datapath
// strobe/select is decoded combinationally from the state, the IR contents
// and the zero/mem_ready inputs.
//
// A wait counter watches FETCH and MEM. If memory fails to respond for
// WAIT_LIMIT consecutive cycles, the controller drops the memory strobe,
// raises bus_err and parks in TRAP until reset.
//
// Parameters:
//   WAIT_LIMIT  consecutive no-ready cycles in FETCH/MEM before a bus error
//               (1..255, default 15)
//
// Optional feature (compile-time macro):
//   DLX_CONTROL_ILLEGAL_TRAP_EN  undefined opcodes/funcs trap with illegal=1;
//                                when undefined they run as a NOP and
//                                illegal is tied low.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   instr      in   IR contents (opcode = [31:26], func = [5:0])
//   zero       in   ALU zero flag (branch condition)
//   mem_ready  in   memory completion strobe
//   alu_op     out  ALU operation code
//   alu_src_b  out  B select: 0 reg B, 1 const 4, 2 sign-extended imm16
//   alu_src_a  out  A select: 0 PC, 1 reg A
//   ir_write, pc_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg
//              out  datapath strobes/selects
//   pc_src     out  PC source: 0 ALU out, 1 branch target, 2 jump target
//   bus_err, illegal, halted
//              out  sticky status flags
//   state      out  current state encoding (debug)
// ----------------------------------------------------------------------------
module dlx_control #(
   parameter int WAIT_LIMIT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        mem_ready,
   output logic [5:0]  alu_op,
   output logic [1:0]  alu_src_b,
   output logic        alu_src_a,
   output logic        ir_write,
   output logic        pc_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic [1:0]  pc_src,
   output logic        bus_err,
   output logic        illegal,
   output logic        halted,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      TRAP   = 3'd6
   } state_t;

`ifdef DLX_CONTROL_ILLEGAL_TRAP_EN
   localparam state_t BAD_NEXT = TRAP;
`else
   localparam state_t BAD_NEXT = FETCH;
`endif

   localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

   state_t     cur, nxt;
   logic [7:0] wait_cnt;
   logic       bus_err_q, halted_q;

   logic [5:0] opcode, func, r_op;
   logic       is_rtype, is_itype, is_lw, is_sw, is_beqz, is_bnez, is_j;
   logic       r_legal, in_access, timeout;
   logic       unused_instr_bits;

   // Opcodes executed by the ALU with an immediate operand
   function automatic logic is_alu_imm(input logic [5:0] op);
      case (op)
         6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h14,
         6'h16, 6'h17, 6'h18, 6'h19, 6'h1A, 6'h1C: return 1'b1;
         default:                                  return 1'b0;
      endcase
   endfunction

   assign opcode            = instr[31:26];
   assign func              = instr[5:0];
   assign unused_instr_bits = ^instr[25:6];

   // R-type funcs fold onto the immediate-form ALU codes; a func is only
   // meaningful if its folded code is one the ALU implements.
   assign r_op     = func[5] ? (func - 6'h18) : (func + 6'h10);
   assign r_legal  = is_alu_imm(r_op);
   assign is_rtype = (opcode == 6'h00);
   assign is_itype = is_alu_imm(opcode);
   assign is_lw    = (opcode == 6'h23);
   assign is_sw    = (opcode == 6'h2B);
   assign is_beqz  = (opcode == 6'h04);
   assign is_bnez  = (opcode == 6'h05);
   assign is_j     = (opcode == 6'h02);

   // Timeout fires in the cycle that would be the WAIT_LIMIT-th without
   // ready; a ready in that same cycle takes priority.
   assign in_access = (cur == FETCH) || (cur == MEM);
   assign timeout   = in_access && !mem_ready && (wait_cnt == LIMIT_M1);

   always_comb begin
      nxt = cur;
      case (cur)
         IDLE:   nxt = FETCH;
         FETCH:  if (mem_ready)    nxt = DECODE;
                 else if (timeout) nxt = TRAP;
         DECODE: nxt = EXEC;
         EXEC:   if ((is_rtype && r_legal) || is_itype) nxt = WB;
                 else if (is_lw || is_sw)                nxt = MEM;
                 else if (is_beqz || is_bnez || is_j)    nxt = FETCH;
                 else                                    nxt = BAD_NEXT;
         MEM:    if (mem_ready)    nxt = is_lw ? WB : FETCH;
                 else if (timeout) nxt = TRAP;
         WB:     nxt = FETCH;
         TRAP:   nxt = TRAP;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      alu_op     = 6'h00;
      alu_src_b  = 2'd0;
      alu_src_a  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      pc_src     = 2'd0;
      case (cur)
         FETCH: begin
            alu_src_b = 2'd1;
            alu_op    = 6'h08;
            mem_read  = !timeout;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
            end
         end
         EXEC: begin
            if (is_rtype && r_legal) begin
               alu_src_a = 1'b1;
               alu_op    = r_op;
            end else if (is_itype) begin
               alu_op    = opcode;
               alu_src_a = 1'b1;
               alu_src_b = 2'd2;
            end else if (is_lw || is_sw) begin
               alu_op    = 6'h08;
               alu_src_a = 1'b1;
               alu_src_b = 2'd2;
            end else if (is_beqz || is_bnez) begin
               alu_src_a = 1'b1;
               pc_src    = 2'd1;
               pc_write  = is_beqz ? zero : !zero;
            end else if (is_j) begin
               pc_src    = 2'd2;
               pc_write  = 1'b1;
            end
         end
         MEM: begin
            if (!timeout) begin
               mem_read  = is_lw;
               mem_write = is_sw;
            end
         end
         WB: begin
            reg_write  = 1'b1;
            reg_dst    = is_rtype;
            mem_to_reg = is_lw;
         end
         default: ;
      endcase
   end

`ifdef DLX_CONTROL_ILLEGAL_TRAP_EN
   logic illegal_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             illegal_q <= 1'b0;
      else if ((cur == EXEC) && (nxt == TRAP)) illegal_q <= 1'b1;
   end

   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur       <= IDLE;
         wait_cnt  <= 8'd0;
         bus_err_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         cur      <= nxt;
         // Staying in FETCH/MEM without ready counts; anything else restarts
         wait_cnt <= (in_access && !mem_ready) ? (wait_cnt + 8'd1) : 8'd0;
         if (timeout)      bus_err_q <= 1'b1;
         if (nxt == TRAP)  halted_q  <= 1'b1;
      end
   end

   assign bus_err = bus_err_q;
   assign halted  = halted_q;
   assign state   = cur;

endmodule

// File: doc/dlx_control.md
DLX_CONTROL -- requirements
Module: dlx_control

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 15, the number of consecutive cycles without mem_ready in FETCH or MEM before a bus error is raised (legal range 1-255).
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port instr  input  32  current IR contents; opcode=instr[31:26], func=instr[5:0].
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  input  1  memory completion strobe.
REQ-007 SHALL have port alu_op  output  6  ALU operation code.
REQ-008 SHALL have port alu_src_b  output  2  ALU B select: 0=reg B, 1=constant 4, 2=sign-extended imm16.
REQ-009 SHALL have port alu_src_a  output  1  ALU A select: 0=PC, 1=reg A.
REQ-010 SHALL have ports ir_write, pc_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg  output  1 each  datapath strobes/selects.
REQ-011 SHALL have port pc_src  output  2  PC source: 0=ALU out, 1=branch target, 2=jump target.
REQ-012 SHALL have ports bus_err, illegal, halted  output  1 each  sticky status flags.
REQ-013 SHALL have port state  output  3  current state encoding, for debug.

Function
REQ-014 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6; state registered, all outputs decoded combinationally from state and instr.
REQ-015 SHALL drive every strobe to 0 and alu_op to 6'h00 in any state where this document does not assert it.
REQ-016 IDLE: no strobes asserted; SHALL go to FETCH on the next edge.
REQ-017 FETCH: SHALL assert mem_read=1, alu_src_a=0, alu_src_b=1, alu_op=6'h08; while mem_ready=0, SHALL stay in FETCH; in the cycle mem_ready=1, SHALL assert ir_write=1 and pc_write=1 (pc_src=0), then go to DECODE.
REQ-018 DECODE: one cycle with no strobes, then EXEC.
REQ-019 EXEC, R-type (opcode 0): SHALL set alu_src_a=1, alu_src_b=0, and alu_op=func-6'h18 when func[5]=1, func+6'h10 otherwise; then go to WB.
REQ-020 EXEC, I-type ALU (opcode in {08,0A,0C,0D,0E,14,16,17,18,19,1A,1C}): SHALL set alu_op=opcode, alu_src_a=1, alu_src_b=2; then go to WB.
REQ-021 EXEC, LW (0x23)/SW (0x2B): SHALL set alu_op=6'h08, alu_src_a=1, alu_src_b=2; then go to MEM.
REQ-022 EXEC, BEQZ (0x04)/BNEZ (0x05): SHALL set alu_op=6'h00, alu_src_a=1, pc_src=1, and pc_write=zero (BEQZ) or !zero (BNEZ); then go to FETCH.
REQ-023 EXEC, J (0x02): SHALL set pc_src=2, pc_write=1; then go to FETCH.
REQ-024 MEM: SHALL hold mem_read=1 (LW) or mem_write=1 (SW) until mem_ready=1; on mem_ready, LW goes to WB and SW goes to FETCH.
REQ-025 WB: SHALL assert reg_write=1, with reg_dst=1 for R-type and 0 otherwise, and mem_to_reg=1 for LW only; then go to FETCH.
REQ-026 SHALL keep an 8-bit wait counter that clears on entry to FETCH/MEM and on mem_ready, and increments each FETCH/MEM cycle with mem_ready=0; when it reaches WAIT_LIMIT, SHALL go to TRAP, set bus_err=1, and drop the memory strobe that cycle.
REQ-027 mem_ready arriving in the same cycle the counter reaches WAIT_LIMIT SHALL win: normal completion, no bus error.
REQ-028 TRAP: all strobes 0, halted=1; absorbing until reset.
REQ-029 mem_ready outside FETCH/MEM SHALL be ignored.

Reset
REQ-030 On rst_n=0, SHALL immediately (asynchronously) set state=IDLE, wait counter=0, and bus_err=illegal=halted=0, so that all outputs are 0.
REQ-031 Reset asserted mid-access SHALL abandon the access; no strobe is asserted while rst_n=0.

Configuration
REQ-032 With DLX_CONTROL_ILLEGAL_TRAP_EN defined, an opcode (or R-type func) not listed in REQ-019..REQ-023 in EXEC SHALL go to TRAP with illegal=1.
REQ-033 Without DLX_CONTROL_ILLEGAL_TRAP_EN, such an instruction SHALL execute as a NOP (EXEC, no strobes, then FETCH), and illegal SHALL be tied to 0.

Verification
REQ-034 Bench SHALL check reset release, then mem_ready=1 on the 2nd FETCH cycle -> states IDLE,FETCH,FETCH,DECODE; ir_write=pc_write=1 only in the ready cycle.
REQ-035 Bench SHALL check instr=ADD R-type (func 0x20) -> EXEC alu_op=6'h08, alu_src_b=0; WB reg_write=1, reg_dst=1.
REQ-036 Bench SHALL check instr=SLLI (0x14) -> alu_op=6'h14, alu_src_b=2; instr=SRA R (func 0x07) -> alu_op=6'h17.
REQ-037 Bench SHALL check LW with mem_ready delayed 3 cycles in MEM -> mem_read held 4 cycles; WB mem_to_reg=1; SW -> mem_write, then FETCH.
REQ-038 Bench SHALL check BEQZ with zero=1 -> pc_write=1, pc_src=1; BNEZ with zero=1 -> pc_write=0; both return to FETCH.
REQ-039 Bench SHALL check WAIT_LIMIT=4 with mem_ready never asserted in FETCH -> TRAP after 4 cycles, bus_err=halted=1; opcode 0x3F with the macro defined -> TRAP with illegal=1, and without it -> returns to FETCH.
